// File: rtl/grf_hazard_pkg.sv
// grf_hazard_pkg: shared definitions for the GRF scoreboard / hazard controller.
//   - Forward-select codes (FWD_GRF/E/M/W)
//   - TUSE_NONE marker for a source register the D instruction does not read
//   - grf_slot_t: one pipeline-stage scoreboard entry {valid, rd, tnew}
//   - sat_dec(): saturating decrement of a tnew counter
package grf_hazard_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] tnew;
  } grf_slot_t;

  localparam grf_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, tnew: 2'd0};

  // One pipeline stage later the result is one cycle closer; never below 0.
  function automatic logic [1:0] sat_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/grf_src_check.sv
// grf_src_check: hazard check and forward selection for one D-stage source.
// Ports:
//   d_valid  in   D holds a real instruction
//   src      in   source register number
//   tuse     in   cycles until the operand is consumed (TUSE_NONE = unused)
//   slot_e/m/w in scoreboard entries of the E, M and W stages
//   hazard   out  this source forces a stall
//   fwd      out  operand source (FWD_GRF/E/M/W)
module grf_src_check
  import grf_hazard_pkg::*;
(
  input  logic      d_valid,
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  grf_slot_t slot_e,
  input  grf_slot_t slot_m,
  input  grf_slot_t slot_w,
  output logic      hazard,
  output logic [1:0] fwd
);

  logic       hit;
  logic [1:0] win_tnew;
  logic [1:0] win_code;

  // Youngest producer wins: an older write to the same register is stale.
  always_comb begin
    hit      = 1'b0;
    win_tnew = 2'd0;
    win_code = FWD_GRF;
    if (src != 5'd0) begin
      if (slot_e.valid && slot_e.rd == src) begin
        hit      = 1'b1;
        win_tnew = slot_e.tnew;
        win_code = FWD_E;
      end else if (slot_m.valid && slot_m.rd == src) begin
        hit      = 1'b1;
        win_tnew = slot_m.tnew;
        win_code = FWD_M;
      end else if (slot_w.valid && slot_w.rd == src) begin
        hit      = 1'b1;
        win_tnew = slot_w.tnew;
        win_code = FWD_W;
      end
    end
  end

  assign hazard = d_valid && (tuse != TUSE_NONE) && hit && (win_tnew > tuse);
  // A producer whose result is not ready yet selects GRF here; the operand is
  // picked up by a later-stage forward once it becomes available.
  assign fwd    = (hit && win_tnew == 2'd0) ? win_code : FWD_GRF;

endmodule

// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl: scoreboard of E/M/W destination registers and result
// readiness; produces the D-stage stall and per-source forward selects.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   d_valid                D holds a real instruction
//   d_rs, d_rt             source registers
//   d_tuse_rs, d_tuse_rt   cycles until each source is used (3 = unused)
//   d_rd, d_tnew           destination and result latency of the D instruction
//   flush                  kill the D instruction (it never enters E)
//   stall                  hold PC/D, bubble into E
//   fwd_rs, fwd_rt         operand source select: 0 GRF, 1 E, 2 M, 3 W
module grf_hazard_ctrl
  import grf_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_rd,
  input  logic [1:0] d_tnew,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt
);

  grf_slot_t slot_e_reg, slot_m_reg, slot_w_reg;
  grf_slot_t slot_e_next, slot_m_next, slot_w_next;
  logic      stall_rs, stall_rt;

  grf_src_check u_chk_rs (
    .d_valid (d_valid),
    .src     (d_rs),
    .tuse    (d_tuse_rs),
    .slot_e  (slot_e_reg),
    .slot_m  (slot_m_reg),
    .slot_w  (slot_w_reg),
    .hazard  (stall_rs),
    .fwd     (fwd_rs)
  );

  grf_src_check u_chk_rt (
    .d_valid (d_valid),
    .src     (d_rt),
    .tuse    (d_tuse_rt),
    .slot_e  (slot_e_reg),
    .slot_m  (slot_m_reg),
    .slot_w  (slot_w_reg),
    .hazard  (stall_rt),
    .fwd     (fwd_rt)
  );

  assign stall = stall_rs | stall_rt;

  always_comb begin
    slot_w_next       = slot_m_reg;
    slot_w_next.tnew  = sat_dec(slot_m_reg.tnew);
    slot_m_next       = slot_e_reg;
    slot_m_next.tnew  = sat_dec(slot_e_reg.tnew);
    slot_e_next       = SLOT_EMPTY;
    // Flush overrides a stall for loading; $0 writes are never tracked.
    if (!stall && !flush && d_valid && d_rd != 5'd0) begin
      slot_e_next.valid = 1'b1;
      slot_e_next.rd    = d_rd;
      slot_e_next.tnew  = d_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_e_reg <= SLOT_EMPTY;
      slot_m_reg <= SLOT_EMPTY;
      slot_w_reg <= SLOT_EMPTY;
    end else begin
      slot_e_reg <= slot_e_next;
      slot_m_reg <= slot_m_next;
      slot_w_reg <= slot_w_next;
    end
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Testbench for grf_hazard_ctrl: directed pipeline scenarios plus random
// traffic, checked against a history-based model of issued instructions.
module tb_grf_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_rd;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;

  always #5 clk = ~clk;

  grf_hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_rd      (d_rd),
    .d_tnew    (d_tnew),
    .flush     (flush),
    .stall     (stall),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: what entered E at each of the last three edges (index = age,
  // 0 = issued at the most recent edge, i.e. now in E).
  bit       h_valid [3];
  int       h_rd    [3];
  int       h_tnew  [3];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Remaining latency of the producer issued `age` edges ago.
  function automatic int remaining(input int age);
    return (h_tnew[age] > age) ? h_tnew[age] - age : 0;
  endfunction

  function automatic void model_src(input int r, input int u,
                                    output bit hz, output int sel);
    hz  = 0;
    sel = 0;
    if (r == 0) return;
    for (int age = 0; age < 3; age++) begin
      if (h_valid[age] && h_rd[age] == r) begin
        hz  = (u != 3) && (remaining(age) > u);
        sel = (remaining(age) == 0) ? age + 1 : 0;
        return;
      end
    end
  endfunction

  task automatic cycle(input bit v, input int rs, input int rt,
                       input int urs, input int urt, input int rd,
                       input int tn, input bit fl, input bit rst);
    bit hz_rs, hz_rt, exp_stall;
    int sel_rs, sel_rt;
    @(negedge clk);
    cyc++;
    d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt);
    d_tuse_rs = 2'(urs); d_tuse_rt = 2'(urt);
    d_rd = 5'(rd); d_tnew = 2'(tn); flush = fl; reset = rst;
    #1;
    model_src(rs, urs, hz_rs, sel_rs);
    model_src(rt, urt, hz_rt, sel_rt);
    exp_stall = v && (hz_rs || hz_rt);
    check("stall", int'(stall), int'(exp_stall));
    check("fwd_rs", int'(fwd_rs), sel_rs);
    check("fwd_rt", int'(fwd_rt), sel_rt);
    $display("cyc=%0d v=%0d rs=%0d/%0d rt=%0d/%0d rd=%0d tnew=%0d fl=%0d rst=%0d -> stall=%0d fwd_rs=%0d fwd_rt=%0d",
             cyc, v, rs, urs, rt, urt, rd, tn, fl, rst, stall, fwd_rs, fwd_rt);
    // Model the coming edge.
    for (int a = 2; a > 0; a--) begin
      h_valid[a] = h_valid[a-1]; h_rd[a] = h_rd[a-1]; h_tnew[a] = h_tnew[a-1];
    end
    h_valid[0] = v && !fl && !exp_stall && rd != 0;
    h_rd[0]    = rd;
    h_tnew[0]  = tn;
    if (rst) begin
      for (int a = 0; a < 3; a++) h_valid[a] = 0;
    end
  endtask

  task automatic bubble();
    cycle(0, 0, 0, 3, 3, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) bubble();
  endtask

  initial begin
    for (int a = 0; a < 3; a++) begin
      h_valid[a] = 0; h_rd[a] = 0; h_tnew[a] = 0;
    end
    reset = 1'b1; d_valid = 0; d_rs = 0; d_rt = 0; d_rd = 0;
    d_tuse_rs = 3; d_tuse_rt = 3; d_tnew = 0; flush = 0;
    repeat (2) @(posedge clk);

    // Reset state, with reset still held.
    cycle(1, 8, 9, 0, 0, 0, 0, 0, 1);

    // lw $8 then beq $8: two stalls, then forward from W.
    cycle(1, 29, 0, 1, 3, 8, 2, 0, 0);
    repeat (3) cycle(1, 8, 0, 0, 0, 0, 0, 0, 0);
    drain();

    // lw $8 then addu $9,$8,$10: one stall.
    cycle(1, 29, 0, 1, 3, 8, 2, 0, 0);
    repeat (2) cycle(1, 8, 10, 1, 1, 9, 1, 0, 0);
    drain();

    // lui $9 then beq $9,$9 held three cycles: selects 1, 2, 3.
    cycle(1, 0, 0, 3, 3, 9, 0, 0, 0);
    repeat (3) cycle(1, 9, 9, 0, 0, 0, 0, 0, 0);
    drain();

    // Two producers of $8 back to back; younger (E, tnew 1) wins.
    cycle(1, 1, 2, 1, 1, 8, 1, 0, 0);
    cycle(1, 3, 4, 1, 1, 8, 1, 0, 0);
    cycle(1, 8, 0, 1, 3, 11, 1, 0, 0);
    drain();

    // Write to $0 is never tracked.
    cycle(1, 0, 0, 3, 3, 0, 2, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();

    // Flushed load never enters E.
    cycle(1, 0, 0, 3, 3, 8, 2, 1, 0);
    cycle(1, 8, 8, 0, 0, 0, 0, 0, 0);
    drain();

    // Reset with a load in M.
    cycle(1, 0, 0, 3, 3, 8, 2, 0, 0);
    cycle(1, 0, 0, 3, 3, 0, 0, 0, 0);
    cycle(1, 8, 8, 0, 0, 0, 0, 0, 1);
    cycle(1, 8, 8, 0, 0, 0, 0, 0, 0);
    drain();

    // Random traffic over a small register set to provoke hazards.
    repeat (400) begin
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
